// File: rtl/aer_event_sender_if.sv
// Bundle of the producer-side push port, the AER link and the status/control
// signals of aer_event_sender. The slave modport is the sender's own view; the
// master modport is the view of whatever drives it (the producer plus the
// downstream receiver).
interface aer_event_sender_if #(
  parameter int AW = 10
);
  timeunit 1ns;
  timeprecision 1ps;

  // Producer side
  logic          ENABLE;
  logic          IN_VALID;
  logic [AW-1:0] IN_ADDR;
  logic          IN_READY;

  // AER link towards the receiver
  logic [AW-1:0] AERIN_ADDR;
  logic          AERIN_REQ;
  logic          AERIN_ACK;

  // Status and control
  logic          BUSY;
  logic          EMPTY;
  logic [15:0]   SENT_CNT;
  logic          TIMEOUT_ERR;
  logic          CLR_ERR;

  modport slave (
    input  ENABLE, IN_VALID, IN_ADDR, AERIN_ACK, CLR_ERR,
    output IN_READY, AERIN_ADDR, AERIN_REQ, BUSY, EMPTY, SENT_CNT, TIMEOUT_ERR
  );

  modport master (
    output ENABLE, IN_VALID, IN_ADDR, AERIN_ACK, CLR_ERR,
    input  IN_READY, AERIN_ADDR, AERIN_REQ, BUSY, EMPTY, SENT_CNT, TIMEOUT_ERR
  );
endinterface

// File: rtl/aer_event_sender.sv
// AER event sender: queues neuron event addresses in a small FIFO and emits
// them one at a time over a 4-phase REQ/ACK handshake. The address is set up
// SETUP_CYC cycles before REQ rises, REQ is held HOLD_CYC cycles after the
// synchronised ACK is seen, and each ACK wait is bounded by TIMEOUT_CYC
// (0 = wait forever). A timed-out event is dropped and flagged.
module aer_event_sender #(
  parameter int M           = 8,
  parameter int DEPTH       = 16,
  parameter int SETUP_CYC   = 5,
  parameter int HOLD_CYC    = 5,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  aer_event_sender_if.slave bus
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam int AW = M + 2;
  localparam int PW = $clog2(DEPTH);

  // Counter compare points. The counter reads 0 in the first cycle of a
  // state, so "N cycles elapsed" is the cycle in which it reads N-1.
  localparam logic [15:0] SETUP_LIM = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LIM  = 16'(HOLD_CYC - 1);
  localparam bit          TO_EN     = (TIMEOUT_CYC > 0);
  // Timeouts beyond the 16-bit counter range clamp to its saturation value.
  localparam logic [15:0] TO_LIM    = (TIMEOUT_CYC > 65536) ? 16'hFFFF :
                                      (TIMEOUT_CYC > 0)     ? 16'(TIMEOUT_CYC - 1) :
                                                              16'h0000;
  localparam logic [PW:0] PTR_ONE   = (PW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    WAIT_ACK = 3'd2,
    HOLD     = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           req_q, req_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [15:0]    sent_q, sent_d;
  logic           err_q, err_d;
  logic           ack_meta_q, ack_meta_d;
  logic           ack_s_q, ack_s_d;
  logic [PW:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  mem [DEPTH];

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           to_set;
  logic [PW-1:0]  wr_idx;
  logic [PW-1:0]  rd_idx;

  assign wr_idx     = wr_ptr_q[PW-1:0];
  assign rd_idx     = rd_ptr_q[PW-1:0];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  // A push while full is dropped simply because IN_READY is low then.
  assign push       = bus.IN_VALID && !fifo_full;

  // Two-flop synchronizer: ACK comes from another timing domain.
  always_comb begin
    ack_meta_d = bus.AERIN_ACK;
    ack_s_d    = ack_meta_q;
  end

  // Handshake FSM: next state, REQ/address outputs, pop and completion count.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      IDLE: begin
        // A receiver still holding ACK from an earlier exchange blocks the
        // next event; ENABLE only gates starting a new one.
        if (bus.ENABLE && !fifo_empty && !ack_s_q) begin
          pop     = 1'b1;
          addr_d  = mem[rd_idx];
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q >= SETUP_LIM) begin
          req_d   = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s_q) begin
          state_d = HOLD;
        end else if (TO_EN && (cnt_q >= TO_LIM)) begin
          req_d   = 1'b0;
          to_set  = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q >= HOLD_LIM) begin
          req_d   = 1'b0;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (!ack_s_q) begin
          sent_d  = sent_q + 16'd1;
          state_d = IDLE;
        end else if (TO_EN && (cnt_q >= TO_LIM)) begin
          to_set  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Per-state cycle counter: restarts on every state change, saturates at max.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Sticky timeout flag; a new timeout wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (to_set) begin
      err_d = 1'b1;
    end else if (bus.CLR_ERR) begin
      err_d = 1'b0;
    end
  end

  // FIFO pointer advance; push and pop in the same cycle leave the level alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // FIFO storage write port; contents need no reset, the pointers define them.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_idx] <= bus.IN_ADDR;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, synchronizer, FIFO pointer and status registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q      <= 16'd0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      sent_q     <= 16'd0;
      err_q      <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
      ack_meta_q <= ack_meta_d;
      ack_s_q    <= ack_s_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all straight from registers or the FIFO pointer compare
  // ---------------------------------------------------------------------
  assign bus.IN_READY    = !fifo_full;
  assign bus.AERIN_ADDR  = addr_q;
  assign bus.AERIN_REQ   = req_q;
  assign bus.BUSY        = (state_q != IDLE);
  assign bus.EMPTY       = fifo_empty;
  assign bus.SENT_CNT    = sent_q;
  assign bus.TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_aer_event_sender.sv
// Bench for aer_event_sender: directed vectors; a scoreboard queue receives
// each accepted address and a monitor compares it when REQ rises.
module tb_aer_event_sender;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int M           = 8;
  localparam int AW          = M + 2;
  localparam int DEPTH       = 16;
  localparam int SETUP_CYC   = 5;
  localparam int HOLD_CYC    = 5;
  localparam int TIMEOUT_CYC = 64;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 0;   // 0: auto responder, 1: hold ACK low, 2: hold ACK high
  int   push_cyc = 0;
  int   events = 0;
  logic [AW-1:0] sb[$];
  logic [AW-1:0] burst_tab [20] = '{
    10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080,
    10'h100, 10'h200, 10'h3FE, 10'h3FD, 10'h3FB, 10'h3F7, 10'h3EF, 10'h3DF,
    10'h123, 10'h234, 10'h345, 10'h056
  };

  aer_event_sender_if #(.AW(AW)) bus ();

  aer_event_sender #(
    .M(M), .DEPTH(DEPTH), .SETUP_CYC(SETUP_CYC),
    .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endfunction

  // Receiver model: answers REQ after 100 ns, or pins ACK for directed tests.
  initial begin
    bus.AERIN_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      case (ack_mode)
        1: bus.AERIN_ACK = 1'b0;
        2: bus.AERIN_ACK = 1'b1;
        default: begin
          if (bus.AERIN_REQ && !bus.AERIN_ACK) begin
            #100; bus.AERIN_ACK = 1'b1;
          end else if (!bus.AERIN_REQ && bus.AERIN_ACK) begin
            #100; bus.AERIN_ACK = 1'b0;
          end
        end
      endcase
    end
  end

  // Monitor: on each REQ rise pop the scoreboard; while REQ is high the
  // address must stay on that expected value.
  initial begin
    logic          req_prev;
    logic [AW-1:0] cur;
    req_prev = 1'b0;
    cur      = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        req_prev = 1'b0;
      end else begin
        if (bus.AERIN_REQ && !req_prev) begin
          events++;
          if (sb.size() == 0) begin
            chk("unexpected_req", 32'(bus.AERIN_ADDR), 32'h0BAD);
          end else begin
            cur = sb.pop_front();
            $display("event %0d addr=0x%03h expected=0x%03h cyc=%0d",
                     events, bus.AERIN_ADDR, cur, cyc);
            chk("event_addr", 32'(bus.AERIN_ADDR), 32'(cur));
          end
        end else if (bus.AERIN_REQ) begin
          chk("addr_stable_during_req", 32'(bus.AERIN_ADDR), 32'(cur));
        end
        req_prev = bus.AERIN_REQ;
      end
    end
  end

  task automatic push(input logic [AW-1:0] a, output bit acc);
    @(negedge CLK);
    bus.IN_VALID = 1'b1;
    bus.IN_ADDR  = a;
    acc = bus.IN_READY;
    @(posedge CLK);
    #1;
    if (acc) begin
      sb.push_back(a);
      push_cyc = cyc;
    end
    $display("push addr=0x%03h accepted=%0d cyc=%0d", a, acc, cyc);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_req(input logic lvl, input int budget, output int at_cyc);
    bit ok;
    ok = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (bus.AERIN_REQ === lvl) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
    chk(lvl ? "wait_req_rise" : "wait_req_fall", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!bus.BUSY && bus.EMPTY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", 32'(ok), 32'd1);
  endtask

  task automatic wait_not_busy(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!bus.BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_not_busy", 32'(ok), 32'd1);
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #1000000;
    $display("FAIL watchdog actual=cyc%0d expected=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int rc, fc, n_acc, first_rej;
    bus.ENABLE   = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_ADDR  = '0;
    bus.CLR_ERR  = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_in_ready", 32'(bus.IN_READY), 32'd1);
    chk("rst_empty", 32'(bus.EMPTY), 32'd1);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_req", 32'(bus.AERIN_REQ), 32'd0);
    chk("rst_addr", 32'(bus.AERIN_ADDR), 32'd0);
    chk("rst_sent", 32'(bus.SENT_CNT), 32'd0);
    chk("rst_err", 32'(bus.TIMEOUT_ERR), 32'd0);
    bus.ENABLE = 1'b1;

    // Single event: latency push -> REQ rise is 1+SETUP_CYC edges
    push(10'h2A5, acc);
    wait_req(1'b1, 30, rc);
    chk("req_latency", 32'(rc - push_cyc), 32'(1 + SETUP_CYC));
    wait_idle(200);
    chk("sent_single", 32'(bus.SENT_CNT), 32'd1);

    // Burst of 20 with sending disabled: exactly DEPTH accepted
    @(negedge CLK);
    bus.ENABLE = 1'b0;
    n_acc = 0;
    first_rej = -1;
    for (int i = 0; i < 20; i++) begin
      push(burst_tab[i], acc);
      if (acc) n_acc++;
      else if (first_rej < 0) first_rej = i;
    end
    chk("burst_accepted", 32'(n_acc), 32'(DEPTH));
    chk("burst_first_reject", 32'(first_rej), 32'(DEPTH));
    chk("burst_in_ready_full", 32'(bus.IN_READY), 32'd0);
    chk("burst_not_empty", 32'(bus.EMPTY), 32'd0);
    chk("burst_disabled_idle", 32'(bus.BUSY), 32'd0);
    bus.ENABLE = 1'b1;
    wait_idle(2000);
    chk("sent_burst", 32'(bus.SENT_CNT), 32'd17);

    // ENABLE drops mid-handshake: current event finishes, next one waits
    push(10'h0F0, acc);
    wait_req(1'b1, 30, rc);
    @(negedge CLK);
    bus.ENABLE = 1'b0;
    push(10'h30F, acc);
    wait_not_busy(300);
    repeat (10) @(negedge CLK);
    chk("en_off_sent", 32'(bus.SENT_CNT), 32'd18);
    chk("en_off_queued", 32'(bus.EMPTY), 32'd0);
    chk("en_off_busy", 32'(bus.BUSY), 32'd0);
    bus.ENABLE = 1'b1;
    wait_idle(300);
    chk("en_on_sent", 32'(bus.SENT_CNT), 32'd19);

    // Timeout in WAIT_ACK: REQ drops after TIMEOUT_CYC, event not counted
    ack_mode = 1;
    push(10'h155, acc);
    wait_req(1'b1, 30, rc);
    wait_req(1'b0, 200, fc);
    chk("timeout_cycles", 32'(fc - rc), 32'(TIMEOUT_CYC));
    chk("timeout_err_set", 32'(bus.TIMEOUT_ERR), 32'd1);
    chk("timeout_sent_same", 32'(bus.SENT_CNT), 32'd19);
    chk("timeout_back_idle", 32'(bus.BUSY), 32'd0);
    @(negedge CLK);
    bus.CLR_ERR = 1'b1;
    @(negedge CLK);
    bus.CLR_ERR = 1'b0;
    chk("err_cleared", 32'(bus.TIMEOUT_ERR), 32'd0);
    ack_mode = 0;
    push(10'h0AA, acc);
    wait_idle(300);
    chk("after_timeout_sent", 32'(bus.SENT_CNT), 32'd20);

    // Timeout set wins over a CLR_ERR held in the same cycle
    ack_mode = 1;
    @(negedge CLK);
    bus.CLR_ERR = 1'b1;
    push(10'h3C3, acc);
    wait_req(1'b1, 30, rc);
    wait_req(1'b0, 200, fc);
    chk("err_set_over_clr", 32'(bus.TIMEOUT_ERR), 32'd1);
    @(negedge CLK);
    chk("err_clr_next", 32'(bus.TIMEOUT_ERR), 32'd0);
    bus.CLR_ERR = 1'b0;
    ack_mode = 0;

    // Stuck ACK: no pop while synchronized ACK is high
    ack_mode = 2;
    repeat (4) @(negedge CLK);
    push(10'h201, acc);
    repeat (20) @(negedge CLK);
    chk("stuck_busy", 32'(bus.BUSY), 32'd0);
    chk("stuck_req", 32'(bus.AERIN_REQ), 32'd0);
    chk("stuck_queued", 32'(bus.EMPTY), 32'd0);
    ack_mode = 0;
    wait_idle(300);
    chk("stuck_sent", 32'(bus.SENT_CNT), 32'd21);

    // Reset while REQ is high discards in-flight and queued events
    ack_mode = 1;
    push(10'h111, acc);
    push(10'h222, acc);
    wait_req(1'b1, 30, rc);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_mid_req", 32'(bus.AERIN_REQ), 32'd0);
    chk("rst_mid_empty", 32'(bus.EMPTY), 32'd1);
    chk("rst_mid_sent", 32'(bus.SENT_CNT), 32'd0);
    chk("rst_mid_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_mid_addr", 32'(bus.AERIN_ADDR), 32'd0);
    sb.delete();
    @(negedge CLK);
    RST = 1'b0;
    ack_mode = 0;

    // Normal operation resumes after reset
    push(10'h3FF, acc);
    wait_idle(300);
    chk("post_rst_sent", 32'(bus.SENT_CNT), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
